// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate front-end and occupancy counter.
// Lane state encoding and default timing constants.
package parking_pkg;

   typedef enum logic [2:0] {
      L_IDLE   = 3'd0,
      L_S_A    = 3'd1,
      L_S_AB   = 3'd2,
      L_S_B    = 3'd3,
      L_WRONG  = 3'd4,
      L_DENIED = 3'd5
   } lane_st_e;

   localparam int DEBOUNCE_CYCLES_DEF  = 4;
   localparam int GATE_HOLD_CYCLES_DEF = 16;
   localparam int CNT_W_DEF            = 5;
   localparam int MAX_SPACES           = 5;

endpackage

// File: rtl/gate_lane_seq.sv
// One lane: beam sync + debounce, direction FSM, barrier hold timer.
// Ports: beam_a_i/beam_b_i raw beams, full_i deny request, done_o/deny_o/wrong_o pulses, gate_o barrier.
module gate_lane_seq
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
   parameter int GATE_HOLD_CYCLES = GATE_HOLD_CYCLES_DEF,
   parameter int CNT_W            = CNT_W_DEF,
   parameter bit ALLOW_DENY       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic beam_a_i,
   input  logic beam_b_i,
   input  logic full_i,
   output logic done_o,
   output logic deny_o,
   output logic wrong_o,
   output logic gate_o
);

   logic [1:0] raw;
   logic [1:0] s1_q;
   logic [1:0] s2_q;
   logic [1:0] db;

   assign raw = {beam_b_i, beam_a_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_db
      logic [CNT_W-1:0] cnt_q;
      logic             db_q;

      // Any agreeing sample restarts the run of differing samples.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
         end else if (s2_q[i] == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            db_q  <= s2_q[i];
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign db[i] = db_q;
   end

   logic a;
   logic b;

   assign a = db[0];
   assign b = db[1];

   lane_st_e         st_q;
   logic [CNT_W-1:0] hold_q;
   logic             gate_q;
   logic             done_q;
   logic             deny_q;
   logic             wrong_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= L_IDLE;
         hold_q  <= '0;
         gate_q  <= 1'b0;
         done_q  <= 1'b0;
         deny_q  <= 1'b0;
         wrong_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         deny_q  <= 1'b0;
         wrong_q <= 1'b0;
         unique case (st_q)
            L_IDLE: begin
               if (a && !b) begin
                  hold_q <= '0;
                  if (ALLOW_DENY && full_i) begin
                     st_q   <= L_DENIED;
                     deny_q <= 1'b1;
                     gate_q <= 1'b0;
                  end else begin
                     st_q   <= L_S_A;
                     gate_q <= 1'b1;
                  end
               end else if (!a && b) begin
                  st_q    <= L_WRONG;
                  wrong_q <= 1'b1;
                  gate_q  <= 1'b0;
                  hold_q  <= '0;
               end else if (hold_q != '0) begin
                  // Gate drops on the edge that exhausts the hold.
                  hold_q <= hold_q - CNT_W'(1);
                  gate_q <= (hold_q != CNT_W'(1));
               end else begin
                  gate_q <= 1'b0;
               end
            end
            L_S_A: begin
               if (a && b) begin
                  st_q <= L_S_AB;
               end else if (!a && !b) begin
                  st_q   <= L_IDLE;
                  hold_q <= CNT_W'(GATE_HOLD_CYCLES);
               end
            end
            L_S_AB: begin
               if (!a && b) begin
                  st_q <= L_S_B;
               end else if (a && !b) begin
                  st_q <= L_S_A;
               end else if (!a && !b) begin
                  st_q   <= L_IDLE;
                  hold_q <= CNT_W'(GATE_HOLD_CYCLES);
               end
            end
            L_S_B: begin
               if (!a && !b) begin
                  st_q   <= L_IDLE;
                  hold_q <= CNT_W'(GATE_HOLD_CYCLES);
                  done_q <= 1'b1;
               end else if (a && b) begin
                  st_q <= L_S_AB;
               end else if (a && !b) begin
                  st_q <= L_S_A;
               end
            end
            L_WRONG, L_DENIED: begin
               if (!a && !b) begin
                  st_q <= L_IDLE;
               end
            end
            default: begin
               st_q   <= L_IDLE;
               gate_q <= 1'b0;
               hold_q <= '0;
            end
         endcase
      end
   end

   assign done_o  = done_q;
   assign deny_o  = deny_q;
   assign wrong_o = wrong_q;
   assign gate_o  = gate_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking front-end: entry/exit lane sequencers plus arrival/depart arbitration.
// Ports: raw beams, parking_full in; car_arrival/car_depart/entry_denied/wrong_way pulses, gate opens out.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
   parameter int GATE_HOLD_CYCLES = GATE_HOLD_CYCLES_DEF,
   parameter int CNT_W            = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic entry_beam_a,
   input  logic entry_beam_b,
   input  logic exit_beam_a,
   input  logic exit_beam_b,
   input  logic parking_full,
   output logic car_arrival,
   output logic car_depart,
   output logic entry_gate_open,
   output logic exit_gate_open,
   output logic entry_denied,
   output logic wrong_way
);

   logic ent_done;
   logic ent_wrong;
   logic ext_done;
   logic ext_wrong;
   logic unused_ext_deny;

   gate_lane_seq #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .GATE_HOLD_CYCLES(GATE_HOLD_CYCLES),
      .CNT_W           (CNT_W),
      .ALLOW_DENY      (1'b1)
   ) u_entry (
      .clk     (clk),
      .rst_n   (reset_n),
      .beam_a_i(entry_beam_a),
      .beam_b_i(entry_beam_b),
      .full_i  (parking_full),
      .done_o  (ent_done),
      .deny_o  (entry_denied),
      .wrong_o (ent_wrong),
      .gate_o  (entry_gate_open)
   );

   gate_lane_seq #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .GATE_HOLD_CYCLES(GATE_HOLD_CYCLES),
      .CNT_W           (CNT_W),
      .ALLOW_DENY      (1'b0)
   ) u_exit (
      .clk     (clk),
      .rst_n   (reset_n),
      .beam_a_i(exit_beam_a),
      .beam_b_i(exit_beam_b),
      .full_i  (1'b0),
      .done_o  (ext_done),
      .deny_o  (unused_ext_deny),
      .wrong_o (ext_wrong),
      .gate_o  (exit_gate_open)
   );

   logic arr_q;
   logic dep_q;
   logic pend_q;
   logic arr_d;
   logic dep_d;
   logic pend_d;

   // Arrival always wins; a depart colliding with it waits one slot.
   always_comb begin
      arr_d  = ent_done;
      dep_d  = !ent_done && (pend_q || ext_done);
      pend_d = ent_done && (pend_q || ext_done);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arr_q  <= 1'b0;
         dep_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         arr_q  <= arr_d;
         dep_q  <= dep_d;
         pend_q <= pend_d;
      end
   end

   assign car_arrival = arr_q;
   assign car_depart  = dep_q;
   assign wrong_way   = ent_wrong | ext_wrong;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl.
// Hand-computed latencies: debounce 2+4 edges, FSM +1, pulse +1, hold 16.
module tb_parking_gate_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ea = 1'b0;
   logic eb = 1'b0;
   logic xa = 1'b0;
   logic xb = 1'b0;
   logic full = 1'b0;
   logic car_arrival;
   logic car_depart;
   logic entry_gate_open;
   logic exit_gate_open;
   logic entry_denied;
   logic wrong_way;

   int n_chk = 0;
   int n_fail = 0;
   int arr_cnt = 0;
   int dep_cnt = 0;
   int den_cnt = 0;
   int ovl_cnt = 0;
   int eg_hi = 0;
   int xg_hi = 0;
   int base0;
   int base1;
   int base2;

   always #5 clk = ~clk;

   parking_gate_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .entry_beam_a   (ea),
      .entry_beam_b   (eb),
      .exit_beam_a    (xa),
      .exit_beam_b    (xb),
      .parking_full   (full),
      .car_arrival    (car_arrival),
      .car_depart     (car_depart),
      .entry_gate_open(entry_gate_open),
      .exit_gate_open (exit_gate_open),
      .entry_denied   (entry_denied),
      .wrong_way      (wrong_way)
   );

   always @(negedge clk) begin
      if (car_arrival) arr_cnt++;
      if (car_depart) dep_cnt++;
      if (entry_denied) den_cnt++;
      if (car_arrival && car_depart) ovl_cnt++;
      if (entry_gate_open) eg_hi++;
      if (exit_gate_open) xg_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      tick(2);
      chk("rst_outs", {26'd0, car_arrival, car_depart, entry_gate_open,
                       exit_gate_open, entry_denied, wrong_way}, 0);
      reset_n = 1'b1;
      tick(5);

      // Full entry sequence
      base0 = arr_cnt;
      ea = 1'b1;
      tick(6);
      chk("t1_gate_pre", entry_gate_open, 0);
      tick(1);
      chk("t1_gate_open", entry_gate_open, 1);
      tick(3);
      eb = 1'b1;
      tick(10);
      ea = 1'b0;
      tick(10);
      chk("t1_gate_sb", entry_gate_open, 1);
      eb = 1'b0;
      tick(7);
      chk("t1_arr_e7", car_arrival, 0);
      tick(1);
      chk("t1_arr_e8", car_arrival, 1);
      tick(1);
      chk("t1_arr_e9", car_arrival, 0);
      tick(13);
      chk("t1_hold_e22", entry_gate_open, 1);
      tick(1);
      chk("t1_hold_e23", entry_gate_open, 0);
      chk("t1_arr_cnt", arr_cnt - base0, 1);
      tick(10);

      // Abort after A only
      base0 = arr_cnt;
      ea = 1'b1;
      tick(10);
      chk("t2_gate_sa", entry_gate_open, 1);
      ea = 1'b0;
      tick(22);
      chk("t2_hold_e22", entry_gate_open, 1);
      tick(1);
      chk("t2_hold_e23", entry_gate_open, 0);
      chk("t2_arr_cnt", arr_cnt - base0, 0);
      tick(10);

      // Denied while full
      base0 = arr_cnt;
      base1 = den_cnt;
      base2 = eg_hi;
      full = 1'b1;
      ea = 1'b1;
      tick(6);
      chk("t3_den_e6", entry_denied, 0);
      tick(1);
      chk("t3_den_e7", entry_denied, 1);
      tick(1);
      chk("t3_den_e8", entry_denied, 0);
      tick(2);
      eb = 1'b1;
      tick(10);
      ea = 1'b0;
      tick(10);
      eb = 1'b0;
      tick(20);
      chk("t3_den_cnt", den_cnt - base1, 1);
      chk("t3_arr_cnt", arr_cnt - base0, 0);
      chk("t3_gate_hi", eg_hi - base2, 0);
      full = 1'b0;
      tick(10);

      // 3-cycle glitch is filtered
      base0 = eg_hi;
      ea = 1'b1;
      tick(3);
      ea = 1'b0;
      tick(20);
      chk("t4_gate_hi", eg_hi - base0, 0);
      tick(5);

      // Simultaneous completion on both lanes
      base0 = arr_cnt;
      base1 = dep_cnt;
      ea = 1'b1; xa = 1'b1;
      tick(10);
      eb = 1'b1; xb = 1'b1;
      tick(10);
      ea = 1'b0; xa = 1'b0;
      tick(10);
      eb = 1'b0; xb = 1'b0;
      tick(8);
      chk("t5_arr_n", car_arrival, 1);
      chk("t5_dep_n", car_depart, 0);
      tick(1);
      chk("t5_arr_n1", car_arrival, 0);
      chk("t5_dep_n1", car_depart, 1);
      tick(1);
      chk("t5_dep_n2", car_depart, 0);
      chk("t5_arr_cnt", arr_cnt - base0, 1);
      chk("t5_dep_cnt", dep_cnt - base1, 1);
      tick(25);

      // Exit wrong way
      base0 = dep_cnt;
      base1 = xg_hi;
      xb = 1'b1;
      tick(7);
      chk("t6_ww_e7", wrong_way, 1);
      tick(1);
      chk("t6_ww_e8", wrong_way, 0);
      tick(2);
      xa = 1'b1;
      tick(10);
      xb = 1'b0;
      tick(10);
      xa = 1'b0;
      tick(25);
      chk("t6_dep_cnt", dep_cnt - base0, 0);
      chk("t6_gate_hi", xg_hi - base1, 0);

      // Reset in S_AB
      xa = 1'b1;
      tick(10);
      xb = 1'b1;
      tick(10);
      chk("t7_gate_sab", exit_gate_open, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t7_rst_outs", {26'd0, car_arrival, car_depart, entry_gate_open,
                          exit_gate_open, entry_denied, wrong_way}, 0);
      xa = 1'b0;
      xb = 1'b0;
      tick(2);
      reset_n = 1'b1;
      base0 = dep_cnt;
      base1 = xg_hi;
      tick(30);
      chk("t7_dep_cnt", dep_cnt - base0, 0);
      chk("t7_gate_hi", xg_hi - base1, 0);
      chk("overlap", ovl_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Front-end sequencer that sits directly upstream of the parking occupancy counter. It synchronises and debounces two beam-break sensor pairs (entry lane, exit lane), decodes direction-of-travel per lane, and emits single-cycle car_arrival / car_depart pulses to the counter. It consumes the counter's parking_full to deny and hold the entry barrier.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a debounced beam changes state
GATE_HOLD_CYCLES, 16, cycles a barrier stays open after its lane returns to IDLE
CNT_W, 5, width of debounce and hold counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, GATE_HOLD_CYCLES)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
entry_beam_a  in  1  entry outer beam broken (async, raw)
entry_beam_b  in  1  entry inner beam broken (async, raw)
exit_beam_a  in  1  exit inner beam broken (async, raw; first beam for an exiting car)
exit_beam_b  in  1  exit outer beam broken (async, raw)
parking_full  in  1  from occupancy counter; 1 = no spaces
car_arrival  out  1  one-cycle pulse: valid entry completed
car_depart  out  1  one-cycle pulse: valid exit completed
entry_gate_open  out  1  entry barrier open command
exit_gate_open  out  1  exit barrier open command
entry_denied  out  1  one-cycle pulse: car at entry refused because full
wrong_way  out  1  one-cycle pulse: lane entered from wrong side

Behaviour:
- Reset (reset_n=0, async): all outputs 0, both lane FSMs IDLE, debounced beams 0, counters 0, pending-depart bit 0.
- Input path: 2-FF synchroniser per beam, then debounce counter; debounced value flips after DEBOUNCE_CYCLES consecutive synchronised samples differing from it; any agreeing sample clears the counter. Raw-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
- Lane FSM (identical per lane; A = first beam, B = second), on debounced A/B:
  IDLE: A&!B -> S_A; !A&B -> WRONG (pulse wrong_way); else stay.
  S_A: A&B -> S_AB; !A&!B -> IDLE (abort, no pulse); else stay.
  S_AB: !A&B -> S_B; A&!B -> S_A (reversing); !A&!B -> IDLE (abort).
  S_B: !A&!B -> IDLE and emit completion; A&B -> S_AB; A&!B -> S_A.
  WRONG: stay until !A&!B -> IDLE; no completion.
  DENIED (entry lane only): entered from IDLE instead of S_A when A&!B and parking_full=1; pulse entry_denied once; stay until !A&!B -> IDLE.
- parking_full is sampled only on the IDLE->S_A/DENIED decision; once in S_A the entry completes even if parking_full rises.
- Completion pulse is registered: output 1 cycle after the FSM reaches IDLE from S_B.
- Output arbitration: car_arrival and car_depart never assert in the same cycle. If both complete together, car_arrival goes first, car_depart is held in a pending bit and asserted the next cycle. Only one pending depart is stored (back-to-back exits are physically ≥ 2*DEBOUNCE_CYCLES apart).
- Gate: lane gate_open = 1 while lane FSM is S_A/S_AB/S_B, and for GATE_HOLD_CYCLES after returning to IDLE via completion or abort. Never opens in WRONG or DENIED. A new S_A entry during hold keeps it open and reloads the counter at the next IDLE.
- Reset mid-sequence: FSM to IDLE, no pulse, gates close immediately.

Decomposition:
- Shared package parking_pkg: lane state encoding (IDLE, S_A, S_AB, S_B, WRONG, DENIED), default DEBOUNCE_CYCLES/GATE_HOLD_CYCLES constants, MAX_SPACES=5 shared with the counter.
- One sub-module gate_lane_seq: synchroniser + debouncers + lane FSM + hold timer, with parameter ALLOW_DENY (1 for entry, 0 for exit); instantiated twice. Top holds arbitration/pending bit.

Test Plan:
- Entry A, A+B, B, clear, each held 10 cycles, parking_full=0 -> exactly one car_arrival pulse; entry_gate_open high from A-debounce until 16 cycles after clear.
- Entry A then clear (no B) -> no car_arrival; gate open then closes after 16-cycle hold.
- Entry A with parking_full=1 -> entry_denied single pulse, entry_gate_open stays 0, no car_arrival even if B sequence follows.
- Raw entry_beam_a glitch 3 cycles wide (DEBOUNCE_CYCLES=4) -> no state change, no gate.
- Entry and exit sequences completing in same cycle -> car_arrival at cycle N, car_depart at N+1, never overlapping.
- Exit lane: B before A -> wrong_way pulse, no car_depart; reset_n low mid-S_AB -> all outputs 0 immediately, no pulse after release.
